// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register file write-back arbiter.
package regfile_pkg;

    localparam int REGFILE_ADDR_W = 5;
    localparam int REGFILE_DATA_W = 32;
    localparam int REG_ZERO       = 0;
    localparam int STARVE_CNT_W   = 4;

    typedef enum logic {
        PRI_MEM = 1'b0,
        PRI_ALU = 1'b1
    } pri_state_t;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_ALU  = 2'd1,
        REQ_MEM  = 2'd2
    } req_t;

endpackage

// File: rtl/regfile_wb_arbiter_bypass.sv
// Same-edge read/write bypass for both register file read ports.
// A write committing at the edge where a read address is sampled is not
// visible in that read's data, so the hit is registered here and presented
// alongside the read data one cycle later.
module regfile_bypass_unit
    import regfile_pkg::*;
#(
    parameter int ADDR_W = REGFILE_ADDR_W,
    parameter int DATA_W = REGFILE_DATA_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] addr_rd,
    input  logic [DATA_W-1:0] data_rd,
    input  logic [ADDR_W-1:0] addr_rs1,
    input  logic [ADDR_W-1:0] addr_rs2,
    output logic              fwd_rs1_valid,
    output logic [DATA_W-1:0] fwd_rs1_data,
    output logic              fwd_rs2_valid,
    output logic [DATA_W-1:0] fwd_rs2_data
);

    logic hit_rs1;
    logic hit_rs2;

    // Address compare against the write committing at the coming edge.
    always_comb begin
        hit_rs1 = write_enable && (addr_rd == addr_rs1) && (addr_rd != ADDR_W'(REG_ZERO));
        hit_rs2 = write_enable && (addr_rd == addr_rs2) && (addr_rd != ADDR_W'(REG_ZERO));
    end

    // Register the hit and the value so they line up with the read data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fwd_rs1_valid <= 1'b0;
            fwd_rs1_data  <= '0;
            fwd_rs2_valid <= 1'b0;
            fwd_rs2_data  <= '0;
        end else begin
            fwd_rs1_valid <= hit_rs1;
            fwd_rs1_data  <= hit_rs1 ? data_rd : '0;
            fwd_rs2_valid <= hit_rs2;
            fwd_rs2_data  <= hit_rs2 ? data_rd : '0;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the single-write-port register file.
// Grants at most one of ALU / load write-back per cycle; the load path has
// priority unless the ALU has lost STARVE_MAX consecutive arbitrations.
// Optional feature macro: REGFILE_BYPASS_EN (builds regfile_bypass_unit;
// otherwise all fwd_* outputs are tied low).
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int ADDR_W     = REGFILE_ADDR_W,
    parameter int DATA_W     = REGFILE_DATA_W,
    parameter int STARVE_MAX = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [ADDR_W-1:0] addr_rs1,
    input  logic [ADDR_W-1:0] addr_rs2,
    output logic              write_enable,
    output logic [ADDR_W-1:0] addr_rd,
    output logic [DATA_W-1:0] data_rd,
    output logic              fwd_rs1_valid,
    output logic              fwd_rs2_valid,
    output logic [DATA_W-1:0] fwd_rs1_data,
    output logic [DATA_W-1:0] fwd_rs2_data
);

    localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

    pri_state_t              state;
    pri_state_t              state_next;
    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic [STARVE_CNT_W-1:0] starve_next;
    logic                    alu_req;
    logic                    mem_req;
    logic                    alu_sink;
    logic                    mem_sink;
    req_t                    grant;

    // Request decode and grant selection; rd == 0 requests are sunk.
    always_comb begin
        alu_req  = alu_valid && (alu_rd != ADDR_W'(REG_ZERO));
        mem_req  = mem_valid && (mem_rd != ADDR_W'(REG_ZERO));
        alu_sink = alu_valid && (alu_rd == ADDR_W'(REG_ZERO));
        mem_sink = mem_valid && (mem_rd == ADDR_W'(REG_ZERO));
        grant    = REQ_NONE;
        if (alu_req && mem_req) begin
            grant = (state == PRI_ALU) ? REQ_ALU : REQ_MEM;
        end else if (alu_req) begin
            grant = REQ_ALU;
        end else if (mem_req) begin
            grant = REQ_MEM;
        end
    end

    assign alu_ready = reset_n && (alu_sink || (grant == REQ_ALU));
    assign mem_ready = reset_n && (mem_sink || (grant == REQ_MEM));

    // Starvation counter and priority next state. The switch to PRI_ALU is
    // taken on the edge where the count reaches the limit, so the ALU wins
    // the very next contested cycle.
    always_comb begin
        starve_next = starve_cnt;
        state_next  = state;
        if ((grant == REQ_ALU) || !alu_valid) begin
            starve_next = '0;
        end else if (alu_req && (starve_cnt != STARVE_LIM)) begin
            starve_next = starve_cnt + 1'b1;
        end
        case (state)
            PRI_MEM: if (starve_next == STARVE_LIM) state_next = PRI_ALU;
            PRI_ALU: if (grant == REQ_ALU)          state_next = PRI_MEM;
            default: state_next = PRI_MEM;
        endcase
    end

    // Priority state and starvation count registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= PRI_MEM;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
        end
    end

    // Registered write port; address and data hold when nothing is granted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            write_enable <= 1'b0;
            addr_rd      <= '0;
            data_rd      <= '0;
        end else begin
            write_enable <= (grant != REQ_NONE);
            if (grant == REQ_ALU) begin
                addr_rd <= alu_rd;
                data_rd <= alu_data;
            end else if (grant == REQ_MEM) begin
                addr_rd <= mem_rd;
                data_rd <= mem_data;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    regfile_bypass_unit #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bypass (
        .clock         (clock),
        .reset_n       (reset_n),
        .write_enable  (write_enable),
        .addr_rd       (addr_rd),
        .data_rd       (data_rd),
        .addr_rs1      (addr_rs1),
        .addr_rs2      (addr_rs2),
        .fwd_rs1_valid (fwd_rs1_valid),
        .fwd_rs1_data  (fwd_rs1_data),
        .fwd_rs2_valid (fwd_rs2_valid),
        .fwd_rs2_data  (fwd_rs2_data)
    );
`else
    // Without bypass the read addresses are not needed; consumers stall instead.
    logic unused_rs;
    assign unused_rs     = ^{addr_rs1, addr_rs2};
    assign fwd_rs1_valid = 1'b0;
    assign fwd_rs2_valid = 1'b0;
    assign fwd_rs1_data  = '0;
    assign fwd_rs2_data  = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed stimulus, a behavioural model of the
// arbitration rules checked every cycle, and literal expectations per scenario.
module tb_regfile_wb_arbiter;

    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 3;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              alu_valid = 1'b0;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd = '0;
    logic [DATA_W-1:0] alu_data = '0;
    logic              mem_valid = 1'b0;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rd = '0;
    logic [DATA_W-1:0] mem_data = '0;
    logic [ADDR_W-1:0] addr_rs1 = '0;
    logic [ADDR_W-1:0] addr_rs2 = '0;
    logic              write_enable;
    logic [ADDR_W-1:0] addr_rd;
    logic [DATA_W-1:0] data_rd;
    logic              fwd_rs1_valid;
    logic              fwd_rs2_valid;
    logic [DATA_W-1:0] fwd_rs1_data;
    logic [DATA_W-1:0] fwd_rs2_data;

    int checks   = 0;
    int failures = 0;

    regfile_wb_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .addr_rs1      (addr_rs1),
        .addr_rs2      (addr_rs2),
        .write_enable  (write_enable),
        .addr_rd       (addr_rd),
        .data_rd       (data_rd),
        .fwd_rs1_valid (fwd_rs1_valid),
        .fwd_rs2_valid (fwd_rs2_valid),
        .fwd_rs1_data  (fwd_rs1_data),
        .fwd_rs2_data  (fwd_rs2_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic              m_we = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_data = '0;
    logic              m_f1v = 1'b0, m_f2v = 1'b0;
    logic [DATA_W-1:0] m_f1d = '0, m_f2d = '0;
    int                m_lost = 0;     // consecutive contested losses of the ALU
    bit                m_owed = 1'b0;  // ALU is owed the next contested win
    logic [DATA_W-1:0] m_rf [32];

    initial foreach (m_rf[i]) m_rf[i] = '0;

    // 0 = none, 1 = alu, 2 = mem
    function automatic int model_grant();
        bit a, m;
        a = alu_valid && (alu_rd != 0);
        m = mem_valid && (mem_rd != 0);
        if (a && m) return m_owed ? 1 : 2;
        if (a) return 1;
        if (m) return 2;
        return 0;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        int g;
        bit h1, h2;
        if (!reset_n) begin
            m_we = 0; m_addr = '0; m_data = '0;
            m_f1v = 0; m_f2v = 0; m_f1d = '0; m_f2d = '0;
            m_lost = 0; m_owed = 0;
        end else begin
            g  = model_grant();
            h1 = BYP && m_we && (m_addr == addr_rs1) && (m_addr != 0);
            h2 = BYP && m_we && (m_addr == addr_rs2) && (m_addr != 0);
            if (m_we) m_rf[m_addr] = m_data;
            m_f1v = h1; m_f1d = h1 ? m_data : '0;
            m_f2v = h2; m_f2d = h2 ? m_data : '0;
            if (g == 1 || !alu_valid) m_lost = 0;
            else if (alu_rd != 0 && m_lost < STARVE_MAX) m_lost = m_lost + 1;
            if (g == 1) m_owed = 0;
            else if (m_lost == STARVE_MAX) m_owed = 1;
            m_we = (g != 0);
            if (g == 1) begin m_addr = alu_rd; m_data = alu_data; end
            if (g == 2) begin m_addr = mem_rd; m_data = mem_data; end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        int g;
        g = model_grant();
        check("we",       write_enable,  m_we);
        check("addr_rd",  addr_rd,       m_addr);
        check("data_rd",  data_rd,       m_data);
        check("fwd1_v",   fwd_rs1_valid, m_f1v);
        check("fwd1_d",   fwd_rs1_data,  m_f1d);
        check("fwd2_v",   fwd_rs2_valid, m_f2v);
        check("fwd2_d",   fwd_rs2_data,  m_f2d);
        check("alu_rdy",  alu_ready, reset_n && alu_valid && (alu_rd == 0 || g == 1));
        check("mem_rdy",  mem_ready, reset_n && mem_valid && (mem_rd == 0 || g == 2));
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [7:0] alu_seq;
        logic [7:0] mem_seq;
        int both;

        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        check("rst_we",   write_enable, 0);
        check("rst_addr", addr_rd, 0);
        check("rst_data", data_rd, 0);
        check("rst_fwd1", fwd_rs1_valid, 0);

        // Single ALU write.
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        #1 check("t1_alu_ready", alu_ready, 1);
        cyc();
        alu_valid = 0;
        check("t1_we",   write_enable, 1);
        check("t1_addr", addr_rd, 5);
        check("t1_data", data_rd, 32'hDEADBEEF);
        cyc();
        check("t1_we_off", write_enable, 0);

        // Continuous contention: mem, mem, mem, alu repeating.
        alu_valid = 1; alu_rd = 3; alu_data = 32'hA;
        mem_valid = 1; mem_rd = 4; mem_data = 32'hB;
        both = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            alu_seq[i] = alu_ready;
            mem_seq[i] = mem_ready;
            if (alu_ready && mem_ready) both++;
            cyc();
        end
        alu_valid = 0; mem_valid = 0;
        check("starve_alu_seq", alu_seq, 8'h88);
        check("starve_mem_seq", mem_seq, 8'h77);
        check("starve_no_both", both, 0);
        cyc();

        // ALU sink with a real load write.
        alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
        mem_valid = 1; mem_rd = 7; mem_data = 32'h77;
        #1;
        check("sink_alu_ready", alu_ready, 1);
        check("sink_mem_ready", mem_ready, 1);
        cyc();
        alu_valid = 0; mem_valid = 0;
        check("sink_we",   write_enable, 1);
        check("sink_addr", addr_rd, 7);
        check("sink_data", data_rd, 32'h77);
        // Starvation count must not have moved: next contest still goes to mem.
        alu_valid = 1; alu_rd = 12; alu_data = 32'h2;
        mem_valid = 1; mem_rd = 12; mem_data = 32'h1;
        #1;
        check("same_mem_first", mem_ready, 1);
        check("same_alu_wait",  alu_ready, 0);
        cyc();
        mem_valid = 0;
        check("same_w1_addr", addr_rd, 12);
        check("same_w1_data", data_rd, 32'h1);
        #1 check("same_alu_now", alu_ready, 1);
        cyc();
        alu_valid = 0;
        check("same_w2_we",   write_enable, 1);
        check("same_w2_data", data_rd, 32'h2);
        cyc();
        check("same_final_rf", m_rf[12], 32'h2);
        cyc();

        // Same-edge bypass on read port 1; port 2 looks elsewhere.
        alu_valid = 1; alu_rd = 9; alu_data = 32'hCAFE0009;
        cyc();
        alu_valid = 0;
        addr_rs1 = 9; addr_rs2 = 8;
        cyc();
        addr_rs1 = 0; addr_rs2 = 0;
        check("byp_rs1_valid", fwd_rs1_valid, BYP);
        check("byp_rs1_data",  fwd_rs1_data, BYP ? 32'hCAFE0009 : 32'h0);
        check("byp_rs2_valid", fwd_rs2_valid, 0);
        cyc();
        check("byp_rs1_clear", fwd_rs1_valid, 0);

        // Reset during a pending write, after the ALU became owed priority.
        alu_valid = 1; alu_rd = 13; alu_data = 32'h13;
        mem_valid = 1; mem_rd = 14; mem_data = 32'h14;
        cyc(); mem_rd = 15; mem_data = 32'h15;
        cyc(); mem_rd = 16; mem_data = 32'h16;
        cyc();
        check("rstmid_we_before", write_enable, 1);
        check("rstmid_addr_before", addr_rd, 16);
        @(negedge clock);
        #1 reset_n = 0;
        #1;
        check("rstmid_we",       write_enable, 0);
        check("rstmid_addr",     addr_rd, 0);
        check("rstmid_alu_rdy",  alu_ready, 0);
        check("rstmid_mem_rdy",  mem_ready, 0);
        cyc();
        reset_n = 1;
        check("rstmid_no_write", m_rf[16], 32'h0);
        check("rstmid_prev_ok",  m_rf[15], 32'h15);
        #1;
        check("rstmid_pri_mem",  mem_ready, 1);
        check("rstmid_alu_wait", alu_ready, 0);
        cyc();
        mem_valid = 0;
        check("rstmid_reissue", data_rd, 32'h16);
        cyc();
        alu_valid = 0;
        check("rstmid_alu_done", addr_rd, 13);
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
